// File: rtl/conv1d_layer_sequencer_if.sv
// Control and datapath-facing signals of the 1-D convolution layer sequencer.
// Widths are derived from the layer shape, so the sequencer and its environment always agree.
interface conv1d_layer_sequencer_if #(
   parameter int ADDR_WIDTH   = 16,
   parameter int KERNEL_SIZE  = 3,
   parameter int INPUT_LENGTH = 8,
   parameter int NUM_FILTERS  = 2
);
   localparam int OUT_LENGTH = INPUT_LENGTH - KERNEL_SIZE + 1;
   localparam int FILT_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int POS_W      = (OUT_LENGTH > 1) ? $clog2(OUT_LENGTH) : 1;

   logic                  start_i;
   logic                  abort_i;
   logic [ADDR_WIDTH-1:0] input_addr_o;
   logic [ADDR_WIDTH-1:0] weight_addr_o;
   logic                  mac_en_o;
   logic                  acc_clr_o;
   logic                  valid_o;
   logic                  ready_i;
   logic [FILT_W-1:0]     out_filter_o;
   logic [POS_W-1:0]      out_pos_o;
   logic                  busy_o;
   logic                  done_o;

   modport master (
      input  start_i, abort_i, ready_i,
      output input_addr_o, weight_addr_o, mac_en_o, acc_clr_o, valid_o,
             out_filter_o, out_pos_o, busy_o, done_o
   );

   modport slave (
      output start_i, abort_i, ready_i,
      input  input_addr_o, weight_addr_o, mac_en_o, acc_clr_o, valid_o,
             out_filter_o, out_pos_o, busy_o, done_o
   );
endinterface

// File: rtl/conv1d_layer_sequencer.sv
// Sequences one 1-D convolution layer: walks filters, output positions and kernel taps over a
// shared MAC datapath, then hands each accumulated result downstream with valid/ready.
module conv1d_layer_sequencer #(
   parameter int ADDR_WIDTH   = 16,
   parameter int KERNEL_SIZE  = 3,
   parameter int INPUT_LENGTH = 8,
   parameter int NUM_FILTERS  = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   conv1d_layer_sequencer_if.master bus
);
   localparam int     OUT_LENGTH = INPUT_LENGTH - KERNEL_SIZE + 1;
   localparam int     TAP_W      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int     POS_W      = (OUT_LENGTH > 1) ? $clog2(OUT_LENGTH) : 1;
   localparam int     FILT_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam longint MAX_IN_ADDR = longint'(INPUT_LENGTH) - 1;
   localparam longint MAX_WT_ADDR = longint'(NUM_FILTERS) * longint'(KERNEL_SIZE) - 1;
   localparam longint ADDR_SPAN   = longint'(1) << ADDR_WIDTH;

   generate
      if (KERNEL_SIZE < 1 || NUM_FILTERS < 1 || INPUT_LENGTH < KERNEL_SIZE) begin : g_bad_shape
         $error("conv1d_layer_sequencer: illegal layer shape");
      end
      if (MAX_IN_ADDR >= ADDR_SPAN || MAX_WT_ADDR >= ADDR_SPAN) begin : g_bad_addr
         $error("conv1d_layer_sequencer: ADDR_WIDTH too narrow for buffer addresses");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t              r_state, w_state_nxt;
   logic [TAP_W-1:0]    r_tap, w_tap_nxt;
   logic [POS_W-1:0]    r_pos, w_pos_nxt;
   logic [FILT_W-1:0]   r_filt, w_filt_nxt;
   logic                r_done, w_done_nxt;

   logic                w_tap_last, w_pos_last, w_filt_last;
   logic                w_mac_en, w_acc_clr, w_valid, w_busy;
   logic [ADDR_WIDTH-1:0] w_input_addr, w_weight_addr;
   logic [FILT_W-1:0]   w_out_filter;
   logic [POS_W-1:0]    w_out_pos;

   assign w_tap_last  = (r_tap  == TAP_W'(KERNEL_SIZE - 1));
   assign w_pos_last  = (r_pos  == POS_W'(OUT_LENGTH - 1));
   assign w_filt_last = (r_filt == FILT_W'(NUM_FILTERS - 1));

   // NOTE: every register uses non-blocking assignment so all of them sample pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= S_IDLE;
         r_tap   <= '0;
         r_pos   <= '0;
         r_filt  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tap   <= w_tap_nxt;
         r_pos   <= w_pos_nxt;
         r_filt  <= w_filt_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_tap_nxt     = r_tap;
      w_pos_nxt     = r_pos;
      w_filt_nxt    = r_filt;
      w_done_nxt    = 1'b0;
      w_mac_en      = 1'b0;
      w_acc_clr     = 1'b0;
      w_valid       = 1'b0;
      w_out_filter  = '0;
      w_out_pos     = '0;
      w_busy        = (r_state != S_IDLE);
      w_input_addr  = '0;
      w_weight_addr = '0;

      if (w_busy) begin
         w_input_addr  = ADDR_WIDTH'(r_pos) + ADDR_WIDTH'(r_tap);
         w_weight_addr = ADDR_WIDTH'(r_filt) * ADDR_WIDTH'(KERNEL_SIZE) + ADDR_WIDTH'(r_tap);
      end

      case (r_state)
         S_IDLE: begin
            if (bus.start_i) begin
               w_state_nxt = S_MAC;
               w_tap_nxt   = '0;
               w_pos_nxt   = '0;
               w_filt_nxt  = '0;
            end
         end
         S_MAC: begin
            w_mac_en  = 1'b1;
            w_acc_clr = (r_tap == '0);
            if (w_tap_last) begin
               w_tap_nxt   = '0;
               w_state_nxt = S_OUT;
            end else begin
               w_tap_nxt = r_tap + 1'b1;
            end
         end
         S_OUT: begin
            w_valid      = 1'b1;
            w_out_filter = r_filt;
            w_out_pos    = r_pos;
            if (bus.ready_i) begin
               if (w_pos_last && w_filt_last) begin
                  w_state_nxt = S_IDLE;
                  w_pos_nxt   = '0;
                  w_filt_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_MAC;
                  if (w_pos_last) begin
                     w_pos_nxt  = '0;
                     w_filt_nxt = r_filt + 1'b1;
                  end else begin
                     w_pos_nxt = r_pos + 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Abort overrides whatever the walk decided, including a final-result done.
      if (bus.abort_i) begin
         w_state_nxt = S_IDLE;
         w_tap_nxt   = '0;
         w_pos_nxt   = '0;
         w_filt_nxt  = '0;
         w_done_nxt  = 1'b0;
      end
   end

   assign bus.mac_en_o      = w_mac_en;
   assign bus.acc_clr_o     = w_acc_clr;
   assign bus.valid_o       = w_valid;
   assign bus.out_filter_o  = w_out_filter;
   assign bus.out_pos_o     = w_out_pos;
   assign bus.busy_o        = w_busy;
   assign bus.input_addr_o  = w_input_addr;
   assign bus.weight_addr_o = w_weight_addr;
   assign bus.done_o        = r_done;
endmodule

// File: tb/tb_conv1d_layer_sequencer.sv
// Directed bench for conv1d_layer_sequencer at the default layer shape (K=3, L=8, F=2 -> 6 outputs/filter).
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_conv1d_layer_sequencer;
   localparam int AW = 16;
   localparam int K  = 3;
   localparam int L  = 8;
   localparam int F  = 2;
   localparam int OL = L - K + 1;
   localparam int NR = F * OL;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   conv1d_layer_sequencer_if #(.ADDR_WIDTH(AW), .KERNEL_SIZE(K), .INPUT_LENGTH(L), .NUM_FILTERS(F)) bus ();

   conv1d_layer_sequencer #(.ADDR_WIDTH(AW), .KERNEL_SIZE(K), .INPUT_LENGTH(L), .NUM_FILTERS(F)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  bus.busy_o, 0);
      check({tag, "_valid"}, bus.valid_o, 0);
      check({tag, "_mac"},   bus.mac_en_o, 0);
      check({tag, "_clr"},   bus.acc_clr_o, 0);
      check({tag, "_done"},  bus.done_o, 0);
      check({tag, "_iaddr"}, bus.input_addr_o, 0);
      check({tag, "_waddr"}, bus.weight_addr_o, 0);
   endtask

   // Entered at the falling edge of the first MAC cycle with ready_i high. Checks every cycle of a
   // full pass against the expected walk: each result takes K MAC cycles and one OUT cycle.
   task automatic run_full(input string tag, input int start_at, input bit start_on_done);
      int c, n, done_c, res, tap;
      c = 0; n = 0; done_c = -1;
      while (c < 100) begin
         if (bus.done_o) begin
            done_c = c;
            break;
         end
         res = c / (K + 1);
         tap = c % (K + 1);
         if (res < NR) begin
            check({tag, "_busy"},  bus.busy_o, 1);
            check({tag, "_mac"},   bus.mac_en_o, (tap < K));
            check({tag, "_valid"}, bus.valid_o, (tap == K));
            check({tag, "_clr"},   bus.acc_clr_o, (tap == 0));
            if (tap < K) begin
               check({tag, "_iaddr"}, bus.input_addr_o, (res % OL) + tap);
               check({tag, "_waddr"}, bus.weight_addr_o, (res / OL) * K + tap);
            end else begin
               check({tag, "_filt"}, bus.out_filter_o, res / OL);
               check({tag, "_pos"},  bus.out_pos_o, res % OL);
               n++;
            end
         end
         bus.start_i = (c == start_at);
         @(negedge clk);
         c++;
      end
      check({tag, "_done_cycle"}, done_c, NR * (K + 1));
      check({tag, "_results"}, n, NR);
      bus.start_i = start_on_done;
      @(negedge clk);
      bus.start_i = 1'b0;
      check({tag, "_done_pulse"}, bus.done_o, 0);
      if (start_on_done) begin
         check({tag, "_restart_mac"},   bus.mac_en_o, 1);
         check({tag, "_restart_busy"},  bus.busy_o, 1);
         check({tag, "_restart_iaddr"}, bus.input_addr_o, 0);
         check({tag, "_restart_waddr"}, bus.weight_addr_o, 0);
      end else begin
         check({tag, "_end_busy"}, bus.busy_o, 0);
         check({tag, "_end_mac"},  bus.mac_en_o, 0);
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.ready_i = 1'b1;

      // Reset state while reset is held
      #1 reset_n = 1'b0;
      #1 check_idle("rst");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_idle("idle");

      // Full pass with a stray start mid-pass, then a start in the done cycle, then a second pass
      bus.start_i = 1'b1;
      @(negedge clk);
      run_full("p1", 5, 1'b1);
      run_full("p2", -1, 1'b0);

      // Backpressure at result (0,2), then abort in the MAC of position 3
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (11) @(negedge clk);
      check("bp_valid0", bus.valid_o, 1);
      check("bp_pos0", bus.out_pos_o, 2);
      bus.ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", bus.valid_o, 1);
         check("bp_pos",   bus.out_pos_o, 2);
         check("bp_filt",  bus.out_filter_o, 0);
         check("bp_mac",   bus.mac_en_o, 0);
      end
      bus.ready_i = 1'b1;
      @(negedge clk);
      check("bp_next_mac",   bus.mac_en_o, 1);
      check("bp_next_iaddr", bus.input_addr_o, 3);
      check("bp_next_clr",   bus.acc_clr_o, 1);
      check("bp_next_valid", bus.valid_o, 0);
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      check_idle("abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", bus.done_o, 0);
         check("abort_stay_idle", bus.busy_o, 0);
      end
      bus.start_i = 1'b1;
      @(negedge clk);
      run_full("p3", -1, 1'b0);

      // Asynchronous reset in the middle of an OUT cycle
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (3) @(negedge clk);
      check("ar_pre_valid", bus.valid_o, 1);
      #2 reset_n = 1'b0;
      #1;
      check("ar_valid", bus.valid_o, 0);
      check("ar_busy",  bus.busy_o, 0);
      check("ar_mac",   bus.mac_en_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_idle("ar_idle");
      bus.start_i = 1'b1;
      @(negedge clk);
      run_full("p4", -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
